led_pager: RTL and testbench
============================

# led_pager

Display scheduler for the six 7-segment digits on the DE10-lite debug panel. Selects one of six CPU debug fields per page (CC, PC, AD, IN, ST, OP), snapshots its value, and produces six 8-bit digit codes, one per `ledctrl` instance. Codes use the `ledctrl` code space: 0–15 for hex nibbles, ASCII for letters, 127 for off. Pages advance by a debounced front-panel button or by an auto-rotate dwell timer.

## Interface
- `DWELL`, default 50_000_000: auto-rotate period in clock cycles (minimum 2).
- `CW`, default `$clog2(DWELL)`: width of the dwell counter.

- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `next_btn` in 1: page-advance request. The signal is already synchronous and debounced. It is level-sensitive; the block edge-detects it internally.
- `auto_en` in 1: enables timed rotation.
- `hold` in 1: freezes the snapshot of the current page.
- `blank` in 1: forces all digits off.
- `cc` in 16: clock-cycle count.
- `pc` in 16: program counter.
- `ad` in 16: address bus.
- `ins` in 8: instruction register.
- `st` in 8: state.
- `op` in 8: opcode.
- `page` out 3: current page index, 0–5.
- `dig5` … `dig0` out 8 each: digit codes, leftmost to rightmost. Each drives one `ledctrl` `value` input.

## Operation
- **Pages.** Each page has an index, a label in `dig5`/`dig4` (as ASCII code), and a source:
  - 0: "CC" (67,67), source `cc`, 16 bits.
  - 1: "PC" (80,67), source `pc`, 16 bits.
  - 2: "AD" (65,68), source `ad`, 16 bits.
  - 3: "IN" (73,78), source `ins`, 8 bits.
  - 4: "ST" (83,84), source `st`, 8 bits.
  - 5: "OP" (79,80), source `op`, 8 bits.
- **Advance event** (`adv`) is asserted in a cycle when either of these holds:
  - button edge: `next_btn`=1 and the registered `btn_q`=0;
  - dwell expiry: `auto_en`=1 and the dwell counter = DWELL-1.
  - When both coincide in one cycle, `page` advances by exactly one.
- **Page register.**
  - On `adv`, `page` ← `page`+1.
  - Wraps 5→0.
  - Values 6–7 are unreachable. If they occur, the next cycle forces `page` to 0.
- **Dwell counter.**
  - Increments while `auto_en`=1.
  - Clears to 0 on any `adv`.
  - Held at 0 while `auto_en`=0.
- **Snapshot `snap[15:0]`.** Priority, highest first:
  1. On `adv`, load from the source of the *new* page, regardless of `hold`.
  2. Otherwise, when `hold`=0, load from the source of the current page.
  3. Otherwise, keep its value.
  - 8-bit sources load zero-extended.
- **Digit formatting.** Registered from `page`/`snap`:
  - 16-bit pages: `dig3`..`dig0` = `snap[15:12]`, `[11:8]`, `[7:4]`, `[3:0]`.
  - 8-bit pages: `dig3` = `dig2` = 127; `dig1` = `snap[7:4]`; `dig0` = `snap[3:0]`.
  - `blank`=1: all six digits = 127 in the next cycle. Paging and snapshotting continue underneath.

## Timing
- **Reset values:**
  - `page` = 0, dwell counter = 0, `btn_q` = 0, `snap` = 0.
  - `dig5`..`dig0` = 127 (all off).
- **First frame after reset release:**
  - Cycle 1: `snap` loads `cc`.
  - Cycle 2: digits show "CC" plus the value.
- **Latency:**
  - Source change → digits update: 2 cycles (source→`snap`→digit registers).
  - `adv` → `page` output: 1 cycle.
  - `adv` → digits show the new label and value: 2 cycles.
- **Button:** a held `next_btn` produces one advance. A new advance requires at least one cycle at 0 in between.
- **Auto period:** with `auto_en` continuously 1, an advance occurs every DWELL cycles.
  - A manual advance restarts the full DWELL interval.
- **Reset mid-operation:** all state returns to its reset values asynchronously, in the same cycle, independent of `clk`.

## Test plan
- **Reset:** assert `reset_n`=0 mid-run with `page`=4 → immediately `page`=0 and all digits 127. After release with `cc`=0x00FF → digits 67,67,0,0,15,15 at cycle 2.
- **Manual advance, 16-bit page:** `pc`=0x1234, single `next_btn` pulse from page 0 → `page`=1 after 1 cycle; digits 80,67,1,2,3,4 after 2 cycles. Holding `next_btn` high for 10 cycles produces only one advance.
- **8-bit page and wrap:** from page 2, `ins`=0xA9, one pulse → digits 73,78,127,127,10,9. Three more pulses → `page`=0 (5→0 wrap).
- **Auto rotation (DWELL=4):** `auto_en`=1 → `page` increments every 4 cycles. A `next_btn` edge on the expiry cycle → a single increment, and the next auto advance comes 4 cycles later.
- **Hold:** on page 2 with `hold`=1, change `ad` 0x0000→0xBEEF → digits unchanged. Then pulse `next_btn` with `ins`=0x42 → digits 73,78,127,127,4,2 despite `hold`.
- **Blank:** `blank`=1 for 5 cycles during auto rotation → all digits 127, `page` keeps advancing. Deassert `blank` → the current page appears 1 cycle later.

Source files
------------

// File: rtl/led_pager.sv
// rtl/led_pager.sv - six-digit debug page scheduler for the 7-segment panel
module led_pager #(
   parameter int DWELL = 50_000_000,
   parameter int CW    = $clog2(DWELL)
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        next_btn,
   input  logic        auto_en,
   input  logic        hold,
   input  logic        blank,
   input  logic [15:0] cc,
   input  logic [15:0] pc,
   input  logic [15:0] ad,
   input  logic [7:0]  ins,
   input  logic [7:0]  st,
   input  logic [7:0]  op,
   output logic [2:0]  page,
   output logic [7:0]  dig5,
   output logic [7:0]  dig4,
   output logic [7:0]  dig3,
   output logic [7:0]  dig2,
   output logic [7:0]  dig1,
   output logic [7:0]  dig0
);

   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
   localparam logic [7:0]    OFF        = 8'd127;

   logic          btn_q;
   logic [CW-1:0] dwell_cnt;
   logic [15:0]   snap;
   logic          btn_edge;
   logic          expire;
   logic          adv;
   logic [2:0]    page_next;
   logic [15:0]   cur_src;
   logic [15:0]   new_src;

   // Source field for a page index; 8-bit fields are zero-extended, bad indices read 0.
   function automatic logic [15:0] page_src(input logic [2:0] p);
      case (p)
         3'd0:    page_src = cc;
         3'd1:    page_src = pc;
         3'd2:    page_src = ad;
         3'd3:    page_src = {8'h00, ins};
         3'd4:    page_src = {8'h00, st};
         3'd5:    page_src = {8'h00, op};
         default: page_src = 16'h0000;
      endcase
   endfunction

   // Advance decision, next page (with wrap and recovery from 6/7), and source muxes.
   always_comb begin
      btn_edge = next_btn & ~btn_q;
      expire   = auto_en & (dwell_cnt == DWELL_LAST);
      adv      = btn_edge | expire;
      if (page > 3'd5)
         page_next = 3'd0;
      else if (adv)
         page_next = (page == 3'd5) ? 3'd0 : page + 3'd1;
      else
         page_next = page;
      cur_src = page_src(page);
      new_src = page_src(page_next);
   end

   // Button history, dwell timer, page index and value snapshot.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         btn_q     <= 1'b0;
         dwell_cnt <= '0;
         page      <= 3'd0;
         snap      <= 16'h0000;
      end else begin
         btn_q <= next_btn;
         page  <= page_next;
         if (adv || !auto_en)
            dwell_cnt <= '0;
         else
            dwell_cnt <= dwell_cnt + CW'(1);
         // A page change always shows fresh data for the new page, even under hold.
         if (adv)
            snap <= new_src;
         else if (!hold)
            snap <= cur_src;
      end
   end

   // Digit codes: label in the two left digits, hex nibbles of the snapshot on the right.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         {dig5, dig4, dig3, dig2, dig1, dig0} <= {6{OFF}};
      end else if (blank) begin
         {dig5, dig4, dig3, dig2, dig1, dig0} <= {6{OFF}};
      end else begin
         case (page)
            3'd0:    {dig5, dig4} <= {8'd67, 8'd67};
            3'd1:    {dig5, dig4} <= {8'd80, 8'd67};
            3'd2:    {dig5, dig4} <= {8'd65, 8'd68};
            3'd3:    {dig5, dig4} <= {8'd73, 8'd78};
            3'd4:    {dig5, dig4} <= {8'd83, 8'd84};
            3'd5:    {dig5, dig4} <= {8'd79, 8'd80};
            default: {dig5, dig4} <= {OFF, OFF};
         endcase
         if (page <= 3'd2) begin
            dig3 <= {4'h0, snap[15:12]};
            dig2 <= {4'h0, snap[11:8]};
         end else begin
            dig3 <= OFF;
            dig2 <= OFF;
         end
         if (page <= 3'd5) begin
            dig1 <= {4'h0, snap[7:4]};
            dig0 <= {4'h0, snap[3:0]};
         end else begin
            dig1 <= OFF;
            dig0 <= OFF;
         end
      end
   end

endmodule

// File: tb/tb_led_pager.sv
// tb/tb_led_pager.sv - vector table, corner sequences and random run against a page model
module tb_led_pager;

   localparam int DWELL = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        next_btn = 1'b0;
   logic        auto_en = 1'b0;
   logic        hold = 1'b0;
   logic        blank = 1'b0;
   logic [15:0] cc = '0, pc = '0, ad = '0;
   logic [7:0]  ins = '0, st = '0, op = '0;
   logic [2:0]  page;
   logic [7:0]  dig5, dig4, dig3, dig2, dig1, dig0;

   int checks = 0;
   int failures = 0;

   led_pager #(.DWELL(DWELL)) dut (
      .clk(clk), .reset_n(reset_n), .next_btn(next_btn), .auto_en(auto_en),
      .hold(hold), .blank(blank), .cc(cc), .pc(pc), .ad(ad), .ins(ins),
      .st(st), .op(op), .page(page), .dig5(dig5), .dig4(dig4), .dig3(dig3),
      .dig2(dig2), .dig1(dig1), .dig0(dig0)
   );

   always #5 clk = ~clk;

   // Reference model state
   int m_page, m_cnt, m_snap;
   bit m_btn;
   int m_dig[6];
   int lab_hi[6] = '{67, 80, 65, 73, 83, 79};
   int lab_lo[6] = '{67, 67, 68, 78, 84, 80};
   int width16[6] = '{1, 1, 1, 0, 0, 0};

   typedef struct {
      logic        btn;
      logic        hld;
      logic        blk;
      logic [15:0] cc_v;
      logic [15:0] pc_v;
      logic [15:0] ad_v;
      logic [7:0]  ins_v;
      int          n;
      int          e_page;
      logic [47:0] e_dig;
   } vec_t;

   vec_t tbl[19];

   function automatic int src_of(int p);
      case (p)
         0: return int'(cc);
         1: return int'(pc);
         2: return int'(ad);
         3: return int'(ins);
         4: return int'(st);
         default: return int'(op);
      endcase
   endfunction

   function automatic int dut_dig(int i);
      case (i)
         5: return int'(dig5);
         4: return int'(dig4);
         3: return int'(dig3);
         2: return int'(dig2);
         1: return int'(dig1);
         default: return int'(dig0);
      endcase
   endfunction

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_page = 0; m_cnt = 0; m_snap = 0; m_btn = 0;
      for (int i = 0; i < 6; i++) m_dig[i] = 127;
   endtask

   // One clock of the display rules, using the inputs as they stand before the edge.
   task automatic model_step();
      bit adv;
      int np;
      int nd[6];
      adv = (next_btn && !m_btn) || (auto_en && m_cnt == DWELL - 1);
      for (int i = 0; i < 6; i++) nd[i] = 127;
      if (!blank) begin
         nd[5] = lab_hi[m_page];
         nd[4] = lab_lo[m_page];
         if (width16[m_page] == 1) begin
            nd[3] = (m_snap / 4096) % 16;
            nd[2] = (m_snap / 256) % 16;
         end
         nd[1] = (m_snap / 16) % 16;
         nd[0] = m_snap % 16;
      end
      np = adv ? (m_page + 1) % 6 : m_page;
      if (adv) m_snap = src_of(np);
      else if (!hold) m_snap = src_of(m_page);
      m_cnt = (adv || !auto_en) ? 0 : m_cnt + 1;
      m_btn = next_btn;
      m_page = np;
      m_dig = nd;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check("model_page", int'(page), m_page);
      for (int i = 0; i < 6; i++) check($sformatf("model_dig%0d", i), dut_dig(i), m_dig[i]);
   endtask

   task automatic check_digs(string name, logic [47:0] e);
      logic [47:0] a;
      a = {dig5, dig4, dig3, dig2, dig1, dig0};
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, a, e, $time);
      end
   endtask

   localparam logic [47:0] ALL_OFF = {6{8'd127}};
   localparam logic [47:0] CC_FF   = {8'd67, 8'd67, 8'd0, 8'd0, 8'd15, 8'd15};
   localparam logic [47:0] PC_1234 = {8'd80, 8'd67, 8'd1, 8'd2, 8'd3, 8'd4};
   localparam logic [47:0] AD_0    = {8'd65, 8'd68, 8'd0, 8'd0, 8'd0, 8'd0};
   localparam logic [47:0] IN_42   = {8'd73, 8'd78, 8'd127, 8'd127, 8'd4, 8'd2};
   localparam logic [47:0] IN_A9   = {8'd73, 8'd78, 8'd127, 8'd127, 8'd10, 8'd9};
   localparam logic [47:0] ST_5A   = {8'd83, 8'd84, 8'd127, 8'd127, 8'd5, 8'd10};
   localparam logic [47:0] OP_C3   = {8'd79, 8'd80, 8'd127, 8'd127, 8'd12, 8'd3};

   initial begin
      int p0;
      int guard;

      //          btn  hld  blk  cc       pc       ad       ins    n  page digits
      tbl[0]  = '{1'b0, 1'b0, 1'b0, 16'h00FF, 16'h1234, 16'h0000, 8'hA9, 2, 0, CC_FF};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 16'h00FF, 16'h1234, 16'h0000, 8'hA9, 1, 1, CC_FF};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, 16'h00FF, 16'h1234, 16'h0000, 8'hA9, 1, 1, PC_1234};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 16'h00FF, 16'h1234, 16'h0000, 8'hA9, 9, 1, PC_1234};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 16'h00FF, 16'h1234, 16'h0000, 8'hA9, 1, 1, PC_1234};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 16'h00FF, 16'h1234, 16'h0000, 8'hA9, 1, 2, PC_1234};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 16'h00FF, 16'h1234, 16'h0000, 8'hA9, 2, 2, AD_0};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 16'h00FF, 16'h1234, 16'hBEEF, 8'hA9, 3, 2, AD_0};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 16'h00FF, 16'h1234, 16'hBEEF, 8'h42, 1, 3, AD_0};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 16'h00FF, 16'h1234, 16'hBEEF, 8'h42, 1, 3, IN_42};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 16'h00FF, 16'h1234, 16'hBEEF, 8'hA9, 2, 3, IN_A9};
      tbl[11] = '{1'b1, 1'b0, 1'b0, 16'h00FF, 16'h1234, 16'hBEEF, 8'hA9, 1, 4, IN_A9};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 16'h00FF, 16'h1234, 16'hBEEF, 8'hA9, 1, 4, ST_5A};
      tbl[13] = '{1'b1, 1'b0, 1'b0, 16'h00FF, 16'h1234, 16'hBEEF, 8'hA9, 1, 5, ST_5A};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 16'h00FF, 16'h1234, 16'hBEEF, 8'hA9, 1, 5, OP_C3};
      tbl[15] = '{1'b1, 1'b0, 1'b0, 16'h00FF, 16'h1234, 16'hBEEF, 8'hA9, 1, 0, OP_C3};
      tbl[16] = '{1'b0, 1'b0, 1'b0, 16'h00FF, 16'h1234, 16'hBEEF, 8'hA9, 1, 0, CC_FF};
      tbl[17] = '{1'b0, 1'b0, 1'b1, 16'h00FF, 16'h1234, 16'hBEEF, 8'hA9, 1, 0, ALL_OFF};
      tbl[18] = '{1'b0, 1'b0, 1'b0, 16'h00FF, 16'h1234, 16'hBEEF, 8'hA9, 1, 0, CC_FF};

      st = 8'h5A;
      op = 8'hC3;
      cc = 16'h00FF;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_page", int'(page), 0);
      check_digs("reset_digits", ALL_OFF);
      reset_n = 1'b1;

      // Directed table
      foreach (tbl[k]) begin
         next_btn = tbl[k].btn;
         hold     = tbl[k].hld;
         blank    = tbl[k].blk;
         cc       = tbl[k].cc_v;
         pc       = tbl[k].pc_v;
         ad       = tbl[k].ad_v;
         ins      = tbl[k].ins_v;
         for (int c = 0; c < tbl[k].n; c++) tick();
         check($sformatf("tbl%0d_page", k), int'(page), tbl[k].e_page);
         check_digs($sformatf("tbl%0d_digits", k), tbl[k].e_dig);
      end

      // Auto rotation: one advance every DWELL cycles
      auto_en = 1'b1;
      p0 = int'(page);
      repeat (DWELL - 1) tick();
      check("auto_hold_page", int'(page), p0);
      tick();
      check("auto_adv1", int'(page), (p0 + 1) % 6);
      repeat (DWELL - 1) tick();
      check("auto_hold_page2", int'(page), (p0 + 1) % 6);
      // Button edge on the expiry cycle gives a single increment
      next_btn = 1'b1;
      tick();
      next_btn = 1'b0;
      check("coincide_single", int'(page), (p0 + 2) % 6);
      repeat (DWELL - 1) tick();
      check("coincide_no_early", int'(page), (p0 + 2) % 6);
      tick();
      check("coincide_next_auto", int'(page), (p0 + 3) % 6);
      // Manual advance mid-interval restarts the dwell
      tick();
      next_btn = 1'b1;
      tick();
      next_btn = 1'b0;
      check("manual_mid", int'(page), (p0 + 4) % 6);
      repeat (DWELL - 1) tick();
      check("restart_no_early", int'(page), (p0 + 4) % 6);
      tick();
      check("restart_full", int'(page), (p0 + 5) % 6);

      // Blank during auto rotation
      p0 = int'(page);
      blank = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         check_digs($sformatf("blank_c%0d", c), ALL_OFF);
      end
      check("blank_page_moves", int'(page != 3'(p0)), 1);
      blank = 1'b0;
      tick();
      check("unblank_label", int'(dig5), lab_hi[m_page]);

      // Asynchronous reset from page 4
      auto_en = 1'b0;
      guard = 0;
      while (m_page != 4 && guard < 20) begin
         next_btn = 1'b1; tick();
         next_btn = 1'b0; tick();
         guard++;
      end
      check("reach_page4", int'(page), 4);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_reset_page", int'(page), 0);
      check_digs("async_reset_digits", ALL_OFF);
      model_reset();
      cc = 16'h00FF;
      hold = 1'b0;
      #1;
      reset_n = 1'b1;
      tick();
      tick();
      check_digs("post_reset_frame", CC_FF);

      // Randomised run against the model
      for (int c = 0; c < 1500; c++) begin
         next_btn = ($urandom % 4) == 0;
         auto_en  = ($urandom % 8) != 0;
         hold     = ($urandom % 3) == 0;
         blank    = ($urandom % 10) == 0;
         cc  = 16'($urandom);
         pc  = 16'($urandom);
         ad  = 16'($urandom);
         ins = 8'($urandom);
         st  = 8'($urandom);
         op  = 8'($urandom);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
